picorv32_mem_arbiter: RTL and testbench

Two-master arbiter that shares one picorv32-style native memory port (valid/ready/addr/wdata/wstrb/rdata/instr) between two requesters, e.g. the core and a debug/DMA agent. It sits between the masters and the single memory or bus port. It grants round-robin, forwards one transaction at a time, and returns responses to the owning master. A wait-state watchdog force-completes transactions that the memory never acknowledges.

---
 rtl/picorv32_mem_arbiter_if.sv | 16 +
 rtl/picorv32_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32-style native memory port bundle.
// master modport: the side that issues requests (valid/instr/addr/wdata/wstrb)
//                 and receives completions (ready/rdata).
// slave modport:  the side that accepts requests and returns completions.
interface picorv32_mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter in front of one picorv32 native memory port.
// One transaction is forwarded at a time. A wait-state watchdog force-completes
// requests the memory never acknowledges.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   s_m0/s_m1  requesting masters (slave modport: we accept their requests)
//   m_mem      shared memory port (master modport: we issue requests)
//   o_owner    index of the granted master, only meaningful while mem valid is high
//   o_timeout  one-cycle pulse on a forced completion
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request forwarded; pick the next master
// ST_BUSY | granted master's request is on the memory port
module picorv32_mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    picorv32_mem_arbiter_if.slave         s_m0,
    picorv32_mem_arbiter_if.slave         s_m1,
    picorv32_mem_arbiter_if.master        m_mem,
    output logic                          o_owner,
    output logic                          o_timeout
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam bit         WD_EN     = (TIMEOUT != 0);
    // Last BUSY cycle before the watchdog fires (wcnt starts at 0 in the first BUSY cycle).
    localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0] r_st;
    logic       r_grant;
    logic       r_last;
    logic [7:0] r_wcnt;

    logic w_busy;
    logic w_sel_valid;
    logic w_done;
    logic w_fire;
    logic w_abort;

    assign w_busy      = (r_st == ST_BUSY);
    assign w_sel_valid = r_grant ? s_m1.valid : s_m0.valid;
    // A master dropping valid mid-transaction aborts silently, even if memory answers.
    assign w_abort     = w_busy && !w_sel_valid;
    assign w_done      = w_busy && w_sel_valid && m_mem.ready;
    // mem_ready in the same cycle wins over the watchdog.
    assign w_fire      = w_busy && w_sel_valid && !m_mem.ready && WD_EN && (r_wcnt == WCNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st    <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;    // m0 wins the first tie
            r_wcnt  <= 8'd0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (s_m0.valid || s_m1.valid) begin
                        r_st   <= ST_BUSY;
                        r_wcnt <= 8'd0;
                        if (s_m0.valid && s_m1.valid)
                            r_grant <= ~r_last;
                        else
                            r_grant <= s_m1.valid;
                    end
                end
                ST_BUSY: begin
                    if (w_abort) begin
                        r_st <= ST_IDLE;
                    end else if (w_done || w_fire) begin
                        r_st   <= ST_IDLE;
                        r_last <= r_grant;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    // Request path: granted master's fields go straight to memory while BUSY,
    // everything is held at zero otherwise.
    always_comb begin
        m_mem.valid = w_busy;
        m_mem.instr = 1'b0;
        m_mem.addr  = 32'h0;
        m_mem.wdata = 32'h0;
        m_mem.wstrb = 4'h0;
        if (w_busy) begin
            if (r_grant) begin
                m_mem.instr = s_m1.instr;
                m_mem.addr  = s_m1.addr;
                m_mem.wdata = s_m1.wdata;
                m_mem.wstrb = s_m1.wstrb;
            end else begin
                m_mem.instr = s_m0.instr;
                m_mem.addr  = s_m0.addr;
                m_mem.wdata = s_m0.wdata;
                m_mem.wstrb = s_m0.wstrb;
            end
        end
    end

    // Response path: only the granted master ever sees ready/rdata; a forced
    // completion returns zero data.
    always_comb begin
        s_m0.ready = 1'b0;
        s_m0.rdata = 32'h0;
        s_m1.ready = 1'b0;
        s_m1.rdata = 32'h0;
        if (r_grant) begin
            s_m1.ready = w_done || w_fire;
            s_m1.rdata = w_done ? m_mem.rdata : 32'h0;
        end else begin
            s_m0.ready = w_done || w_fire;
            s_m0.rdata = w_done ? m_mem.rdata : 32'h0;
        end
    end

    assign o_owner   = w_busy && r_grant;
    assign o_timeout = w_fire;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    logic owner;
    logic tmo;

    always #5 clk = ~clk;

    picorv32_mem_arbiter_if m0_if ();
    picorv32_mem_arbiter_if m1_if ();
    picorv32_mem_arbiter_if mem_if ();

    picorv32_mem_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .s_m0      (m0_if),
        .s_m1      (m1_if),
        .m_mem     (mem_if),
        .o_owner   (owner),
        .o_timeout (tmo)
    );

    int total = 0;
    int bad   = 0;
    bit model_last;   // last master served, per the round-robin rule

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int i, input logic v, input logic ins,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (i == 0) begin
            m0_if.valid = v; m0_if.instr = ins; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
        end else begin
            m1_if.valid = v; m1_if.instr = ins; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_m(0, 1'b1, 1'b1, 32'h55, 32'h66, 4'hF);
        drive_m(1, 1'b1, 1'b0, 32'h77, 32'h88, 4'h1);
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'hFFFF_FFFF;
        tick(); tick();
        total++; if (mem_if.valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_if.valid); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", tmo); end
        total++; if ({m0_if.ready, m1_if.ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", m0_if.ready, m1_if.ready); end
        total++; if ({m0_if.rdata, m1_if.rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_if.rdata, m1_if.rdata); end
        total++; if ({mem_if.addr, mem_if.wdata, mem_if.wstrb, mem_if.instr} !== 69'h0) begin bad++; $display("FAIL reset_mem_fields got=%h/%h/%h/%b exp=0", mem_if.addr, mem_if.wdata, mem_if.wstrb, mem_if.instr); end
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'h0;
        #2 rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        drive_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        #1;
        total++; if (mem_if.valid !== 1'b0) begin bad++; $display("FAIL single_t0_valid got=%b exp=0", mem_if.valid); end
        tick();
        mem_if.ready = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (mem_if.valid !== 1'b1 || mem_if.addr !== 32'h100) begin bad++; $display("FAIL single_t1_mem got=%b/%h exp=1/00000100", mem_if.valid, mem_if.addr); end
        total++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_t1_resp got=%b/%h exp=1/deadbeef", m0_if.ready, m0_if.rdata); end
        total++; if (m1_if.ready !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL single_t1_other got=%b/%b exp=0/0", m1_if.ready, tmo); end
        model_last = 1'b0;
        tick();
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        #1;
        total++; if (mem_if.valid !== 1'b0) begin bad++; $display("FAIL single_t2_valid got=%b exp=0", mem_if.valid); end
    endtask

    task automatic test_tie_fairness();
        bit exp_own;
        tick();
        drive_m(0, 1'b1, 1'b1, 32'hA0, 32'h0, 4'h0);
        drive_m(1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'h0);
        mem_if.ready = 1'b1; mem_if.rdata = 32'h1234;
        for (int n = 1; n <= 8; n++) begin
            tick();
            #1;
            if (n % 2 == 1) begin
                exp_own = !model_last;
                total++; if (mem_if.valid !== 1'b1 || owner !== exp_own) begin bad++; $display("FAIL tie_busy n=%0d got=%b/%b exp=1/%b", n, mem_if.valid, owner, exp_own); end
                total++; if ({m1_if.ready, m0_if.ready} !== (exp_own ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_ready n=%0d got=%b%b owner=%b", n, m1_if.ready, m0_if.ready, exp_own); end
                total++; if (mem_if.addr !== (exp_own ? 32'hB0 : 32'hA0)) begin bad++; $display("FAIL tie_addr n=%0d got=%h", n, mem_if.addr); end
                model_last = exp_own;
            end else begin
                total++; if (mem_if.valid !== 1'b0 || {m1_if.ready, m0_if.ready} !== 2'b00) begin bad++; $display("FAIL tie_idle n=%0d got=%b/%b%b exp=0/00", n, mem_if.valid, m1_if.ready, m0_if.ready); end
            end
        end
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
    endtask

    task automatic test_write_forwarding();
        tick();
        drive_m(1, 1'b1, 1'b0, 32'h0000_2468, 32'h1234_5678, 4'b0011);
        for (int k = 1; k <= 4; k++) begin
            tick();
            mem_if.ready = (k == 4); mem_if.rdata = 32'h0BAD_0000 + k;
            #1;
            total++; if (mem_if.valid !== 1'b1 || owner !== 1'b1 || mem_if.addr !== 32'h2468 || mem_if.wdata !== 32'h1234_5678 || mem_if.wstrb !== 4'b0011 || mem_if.instr !== 1'b0) begin
                bad++; $display("FAIL write_fields k=%0d got=%b/%b/%h/%h/%b", k, mem_if.valid, owner, mem_if.addr, mem_if.wdata, mem_if.wstrb);
            end
            total++; if (m1_if.ready !== (k == 4) || m0_if.ready !== 1'b0) begin bad++; $display("FAIL write_ready k=%0d got m1=%b m0=%b exp m1=%b m0=0", k, m1_if.ready, m0_if.ready, (k == 4)); end
        end
        model_last = 1'b1;
        tick();
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        #1;
        total++; if (mem_if.valid !== 1'b0) begin bad++; $display("FAIL write_after_valid got=%b exp=0", mem_if.valid); end
    endtask

    task automatic test_timeout();
        tick();
        drive_m(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        mem_if.rdata = 32'hAAAA_5555;
        for (int k = 1; k <= TO; k++) begin
            tick();
            #1;
            total++; if (mem_if.valid !== 1'b1 || m0_if.ready !== (k == TO) || tmo !== (k == TO) || m0_if.rdata !== 32'h0) begin
                bad++; $display("FAIL timeout k=%0d got valid=%b rdy=%b tmo=%b rdata=%h exp rdy=tmo=%b rdata=0", k, mem_if.valid, m0_if.ready, tmo, m0_if.rdata, (k == TO));
            end
        end
        model_last = 1'b0;
        tick();
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (mem_if.valid !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL timeout_after got=%b/%b exp=0/0", mem_if.valid, tmo); end
    endtask

    task automatic test_simultaneous();
        tick();
        drive_m(1, 1'b1, 1'b1, 32'h400, 32'h0, 4'h0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            mem_if.ready = (k == TO); mem_if.rdata = 32'hCAFE_F00D;
            #1;
            total++; if (m1_if.ready !== (k == TO) || tmo !== 1'b0) begin bad++; $display("FAIL simul_ready k=%0d got=%b/%b exp=%b/0", k, m1_if.ready, tmo, (k == TO)); end
        end
        total++; if (m1_if.rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL simul_rdata got=%h exp=cafef00d", m1_if.rdata); end
        model_last = 1'b1;
        tick();
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
    endtask

    task automatic test_protocol_violation();
        tick();
        drive_m(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        tick();
        tick();
        drive_m(0, 1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
        mem_if.ready = 1'b1;
        #1;
        total++; if (mem_if.valid !== 1'b1 || m0_if.ready !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL abort_cycle got=%b/%b/%b exp=1/0/0", mem_if.valid, m0_if.ready, tmo); end
        tick();
        mem_if.ready = 1'b0;
        #1;
        total++; if (mem_if.valid !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", mem_if.valid); end
    endtask

    task automatic test_reset_mid_busy();
        tick();
        drive_m(1, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        total++; if (mem_if.valid !== 1'b0 || owner !== 1'b0 || m1_if.ready !== 1'b0 || tmo !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%b/%b/%b/%b exp=0/0/0/0", mem_if.valid, owner, m1_if.ready, tmo);
        end
        tick();
        drive_m(0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        #2 rst = 1'b0;
        model_last = 1'b1;
        tick();
        mem_if.ready = 1'b1; mem_if.rdata = 32'h0000_0777;
        #1;
        total++; if (mem_if.valid !== 1'b1 || owner !== 1'b0 || m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h777) begin
            bad++; $display("FAIL post_reset_grant got=%b/%b/%b/%h exp=1/0/1/00000777", mem_if.valid, owner, m0_if.ready, m0_if.rdata);
        end
        model_last = 1'b0;
        tick();
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
    endtask

    // Transaction-level model: pending masters, round-robin choice, random wait
    // states; completion at wait+1 BUSY cycles or at the TO-th cycle, whichever first.
    task automatic test_random();
        bit          pend [2];
        logic        f_ins [2];
        logic [31:0] f_addr [2];
        logic [31:0] f_data [2];
        logic [3:0]  f_strb [2];
        bit          g, done, exp_rdy, exp_tmo;
        int          w;
        logic [31:0] exp_rd, got_rd;
        pend[0] = 0; pend[1] = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0 || (!pend[0] && !pend[1] && i == 1))) begin
                    pend[i]   = 1;
                    f_ins[i]  = 1'($urandom_range(0, 1));
                    f_addr[i] = $urandom & 32'hFFFF_FFFC;
                    f_data[i] = $urandom;
                    f_strb[i] = 4'($urandom_range(0, 15));
                end
                drive_m(i, pend[i], f_ins[i], f_addr[i], f_data[i], f_strb[i]);
            end
            mem_if.ready = 1'($urandom_range(0, 1));
            mem_if.rdata = $urandom;
            #1;
            total++; if (mem_if.valid !== 1'b0 || {m1_if.ready, m0_if.ready} !== 2'b00 || tmo !== 1'b0) begin
                bad++; $display("FAIL rnd_idle t=%0d got=%b/%b%b/%b", t, mem_if.valid, m1_if.ready, m0_if.ready, tmo);
            end
            g = (pend[0] && pend[1]) ? !model_last : pend[1];
            w = $urandom_range(0, TO + 2);
            done = 0;
            for (int k = 1; k <= TO + 1 && !done; k++) begin
                tick();
                mem_if.ready = (k == w + 1);
                mem_if.rdata = $urandom;
                #1;
                exp_rdy = (k == w + 1) || (k == TO);
                exp_tmo = (k == TO) && (k != w + 1);
                exp_rd  = (k == w + 1) ? mem_if.rdata : 32'h0;
                got_rd  = g ? m1_if.rdata : m0_if.rdata;
                total++; if (mem_if.valid !== 1'b1 || owner !== g || mem_if.addr !== f_addr[g] || mem_if.wdata !== f_data[g] || mem_if.wstrb !== f_strb[g] || mem_if.instr !== f_ins[g]) begin
                    bad++; $display("FAIL rnd_fwd t=%0d k=%0d got own=%b addr=%h exp own=%b addr=%h", t, k, owner, mem_if.addr, g, f_addr[g]);
                end
                total++; if ((g ? m1_if.ready : m0_if.ready) !== exp_rdy || got_rd !== exp_rd || tmo !== exp_tmo) begin
                    bad++; $display("FAIL rnd_resp t=%0d k=%0d got rdy=%b rd=%h tmo=%b exp rdy=%b rd=%h tmo=%b", t, k, (g ? m1_if.ready : m0_if.ready), got_rd, tmo, exp_rdy, exp_rd, exp_tmo);
                end
                total++; if ((g ? m0_if.ready : m1_if.ready) !== 1'b0 || (g ? m0_if.rdata : m1_if.rdata) !== 32'h0) begin
                    bad++; $display("FAIL rnd_other t=%0d k=%0d got rdy=%b rd=%h exp=0/0", t, k, (g ? m0_if.ready : m1_if.ready), (g ? m0_if.rdata : m1_if.rdata));
                end
                if (exp_rdy) begin
                    done = 1;
                    model_last = g;
                    pend[g] = 0;
                end
            end
            if (!done) begin
                total++; bad++;
                $display("FAIL rnd_bound t=%0d no completion within %0d cycles", t, TO + 1);
                pend[g] = 0;
            end
        end
        tick();
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        tick();
    endtask

    initial begin
        drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'h0;
        test_reset();
        test_single_read();
        test_tie_fairness();
        test_write_forwarding();
        test_timeout();
        test_simultaneous();
        test_protocol_violation();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end
endmodule
